// File: rtl/dm_pkg.sv
// Shared constants, entry layout and byte-enable helper for the data-memory store buffer.
package dm_pkg;

  localparam logic [2:0] DM_WORD = 3'd0;
  localparam logic [2:0] DM_HALF = 3'd1;
  localparam logic [2:0] DM_BYTE = 3'd2;

  typedef struct packed {
    logic [29:0] word_addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] pc;
  } sb_entry_t;

  // Unknown access types fall back to a full-word mask.
  function automatic logic [3:0] dm_be_gen(input logic [1:0] addr_lo, input logic [2:0] acc_type);
    case (acc_type)
      DM_BYTE: dm_be_gen = 4'b0001 << addr_lo;
      DM_HALF: dm_be_gen = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: dm_be_gen = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/sb_lane_align.sv
// Moves right-aligned store data into its memory byte lanes and flags misaligned accesses.
module sb_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  acc_type,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_data,
  output logic        misalign
);

  always_comb begin
    be        = dm_be_gen(addr_lo, acc_type);
    lane_data = wdata;
    misalign  = 1'b0;
    case (acc_type)
      DM_BYTE: begin
        lane_data = {24'b0, wdata[7:0]} << {addr_lo, 3'b000};
      end
      DM_HALF: begin
        lane_data = addr_lo[1] ? {wdata[15:0], 16'b0} : {16'b0, wdata[15:0]};
        misalign  = addr_lo[0];
      end
      default: begin
        lane_data = wdata;
        misalign  = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/dm_store_buffer.sv
// In-order store buffer in front of the data-memory write port, with load lookup.
// Define DM_SB_FORWARD_EN to forward fully covered loads; otherwise any match stalls.
module dm_store_buffer
  import dm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [2:0]  st_type,
  input  logic [31:0] st_pc,
  output logic        st_misalign,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_type,
  output logic        ld_hit,
  output logic [31:0] ld_data,
  output logic        ld_stall,
  output logic        dm_we,
  input  logic        dm_ready,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_pc,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t     mem [DEPTH];
  sb_entry_t     head_entry;
  logic [PW-1:0] head, tail, idx;
  logic [CW-1:0] count;
  logic [3:0]    st_be, req_be;
  logic [31:0]   st_lane;
  logic          st_mis, push, pop, match;

  sb_lane_align u_st_align (
    .addr_lo   (st_addr[1:0]),
    .acc_type  (st_type),
    .wdata     (st_wdata),
    .be        (st_be),
    .lane_data (st_lane),
    .misalign  (st_mis)
  );

  assign st_ready = (count != CW'(DEPTH));
  assign empty    = (count == '0);
  assign dm_we    = !empty;
  assign push     = st_valid && st_ready && !st_mis;
  assign pop      = dm_we && dm_ready;
  assign req_be   = dm_be_gen(ld_addr[1:0], ld_type);

  // Gating on dm_we keeps stale slot contents off the port while empty or in reset.
  assign head_entry = mem[head];
  assign dm_addr    = dm_we ? {head_entry.word_addr, 2'b00} : '0;
  assign dm_wdata   = dm_we ? head_entry.data : '0;
  assign dm_be      = dm_we ? head_entry.be : '0;
  assign dm_pc      = dm_we ? head_entry.pc : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      st_misalign <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      st_misalign <= st_valid && st_ready && st_mis;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{word_addr: st_addr[31:2], data: st_lane, be: st_be, pc: st_pc};
  end

`ifdef DM_SB_FORWARD_EN
  logic [3:0]  match_be;
  logic [31:0] match_data;

  // Walk oldest to youngest so the last overlapping entry wins.
  always_comb begin
    match      = 1'b0;
    match_be   = '0;
    match_data = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (mem[idx].word_addr == ld_addr[31:2]) &&
          ((mem[idx].be & req_be) != 4'b0000)) begin
        match      = 1'b1;
        match_be   = mem[idx].be;
        match_data = mem[idx].data;
      end
    end
  end

  assign ld_hit   = ld_valid && match && ((match_be & req_be) == req_be);
  assign ld_stall = ld_valid && match && ((match_be & req_be) != req_be);
  assign ld_data  = ld_hit ? match_data : '0;
`else
  always_comb begin
    match = 1'b0;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (mem[idx].word_addr == ld_addr[31:2]) &&
          ((mem[idx].be & req_be) != 4'b0000)) begin
        match = 1'b1;
      end
    end
  end

  assign ld_hit   = 1'b0;
  assign ld_stall = ld_valid && match;
  assign ld_data  = '0;
`endif

endmodule
